// File: rtl/pool_unit.sv
// pool_unit: streaming 2x2 / stride-2 pooling stage for post-ReLU activations.
// Takes one sample per accepted cycle in row-major order. Emits one pooled value
// for each complete 2x2 window.
// Build option: define POOL_AVG_EN for average pooling. Max pooling is the default.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   ce                enable; samples are discarded and state holds while low
//   pool_din_vld      input sample valid
//   pool_din[N-1:0]   input activation (unsigned)
//   pool_dout[N-1:0]  pooled result, registered, holds between windows
//   pool_dout_vld     one-cycle pulse per completed window
//   pool_dout_end     pulses with pool_dout_vld on the last window of a frame
module pool_unit #(
    parameter int unsigned N          = 16,
    parameter int unsigned INPUT_SIZE = 28
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         pool_din_vld,
    input  logic [N-1:0] pool_din,
    output logic [N-1:0] pool_dout,
    output logic         pool_dout_vld,
    output logic         pool_dout_end
);

    localparam int unsigned OUTPUT_SIZE = INPUT_SIZE / 2;
    localparam int unsigned CW          = (INPUT_SIZE > 2) ? $clog2(INPUT_SIZE) : 1;
    localparam int unsigned LBW         = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam int unsigned LAST_IDX    = INPUT_SIZE - 1;
    localparam int unsigned WIN_LAST    = 2 * OUTPUT_SIZE - 1;
`ifdef POOL_AVG_EN
    localparam int unsigned PW          = N + 1;
    localparam int unsigned SW          = N + 2;
`else
    localparam int unsigned PW          = N;
`endif

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [N-1:0]  hold_q, hold_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          vld_q, vld_d;
    logic          end_q, end_d;

    logic [PW-1:0] linebuf_q [OUTPUT_SIZE];
    logic          lb_we;
    logic [LBW-1:0] lb_idx;
    logic [PW-1:0] lb_rd;
    logic [PW-1:0] pair;
    logic [N-1:0]  result;
    logic          accept;

    assign accept = ce & pool_din_vld;
    assign lb_idx = LBW'(col_q >> 1);
    assign lb_rd  = linebuf_q[lb_idx];

    // Horizontal pair (held even-column sample with current odd-column sample) and window result.
`ifdef POOL_AVG_EN
    logic [SW-1:0] win_sum;
    assign pair    = PW'(hold_q) + PW'(pool_din);
    assign win_sum = SW'(pair) + SW'(lb_rd);
    assign result  = N'(win_sum >> 2);
`else
    assign pair    = (pool_din > hold_q) ? pool_din : hold_q;
    assign result  = (pair > lb_rd) ? pair : lb_rd;
`endif

    // Next-state: counters, pair hold, linebuf write strobe and output register.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        hold_d = hold_q;
        dout_d = dout_q;
        vld_d  = 1'b0;
        end_d  = 1'b0;
        lb_we  = 1'b0;
        if (accept) begin
            if (!col_q[0]) begin
                hold_d = pool_din;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                // Odd row and odd column index are always inside the floor(INPUT_SIZE/2) grid.
                dout_d = result;
                vld_d  = 1'b1;
                end_d  = (row_q == CW'(WIN_LAST)) && (col_q == CW'(WIN_LAST));
            end
            if (col_q == CW'(LAST_IDX)) begin
                col_d = '0;
                row_d = (row_q == CW'(LAST_IDX)) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            hold_q <= '0;
            dout_q <= '0;
            vld_q  <= 1'b0;
            end_q  <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            hold_q <= hold_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
            end_q  <= end_d;
        end
    end

    // The line buffer has no reset: each entry is written in an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[lb_idx] <= pair;
        end
    end

    assign pool_dout     = dout_q;
    assign pool_dout_vld = vld_q;
    assign pool_dout_end = end_q;

endmodule
